// File: rtl/lfsr_gen_if.sv
// lfsr_gen_if: control and observation bundle for lfsr_gen.
//   en        advance one step this cycle
//   load      parallel load (wins over en)
//   load_val  value written on load
//   q         current LFSR state
//   sout      serial output bit
//   wrap      one-cycle pulse when a step lands on SEED
//   lockup    one-cycle pulse when a zero load was replaced by SEED
//   period    steps between the last two returns to SEED
// Modports: master drives controls (bench/user), slave is the generator.
interface lfsr_gen_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic             wrap;
  logic             lockup;
  logic [WIDTH-1:0] period;

  modport master (
    output en, load, load_val,
    input  q, sout, wrap, lockup, period
  );

  modport slave (
    input  en, load, load_val,
    output q, sout, wrap, lockup, period
  );
endinterface

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised LFSR with Fibonacci or Galois topology, step enable,
// parallel load with all-zero substitution, serial output and a hardware
// period measurement.
// Ports:
//   clk     rising-edge clock
//   set_n   asynchronous active-low reset, loads SEED
//   bus_io  lfsr_gen_if slave: en/load/load_val in; q/sout/wrap/lockup/period out
module lfsr_gen #(
  parameter int unsigned      WIDTH  = 4,
  parameter logic [WIDTH-1:0] TAPS   = 4'b1100,
  parameter logic [WIDTH-1:0] SEED   = 4'b0001,
  parameter bit               GALOIS = 1'b0
) (
  input  logic       clk,
  input  logic       set_n,
  lfsr_gen_if.slave  bus_io
);

  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_gen: SEED must be nonzero");
  end
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("lfsr_gen: WIDTH must be in 2..32");
  end
  if (TAPS[WIDTH-1] != 1'b1) begin : g_bad_taps
    $error("lfsr_gen: TAPS[WIDTH-1] must be set");
  end

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             wrap_q, wrap_d;
  logic             lockup_q, lockup_d;

  logic [WIDTH-1:0] step_fib;
  logic [WIDTH-1:0] step_gal;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] cnt_inc;

  always_comb begin
    step_fib = {q_q[WIDTH-2:0], ^(q_q & TAPS)};
    step_gal = {1'b0, q_q[WIDTH-1:1]} ^ ({WIDTH{q_q[0]}} & TAPS);
    q_step   = GALOIS ? step_gal : step_fib;
    // Step counter saturates so a cycle that never revisits SEED cannot wrap it.
    cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + WIDTH'(1);
  end

  always_comb begin
    q_d      = q_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    wrap_d   = 1'b0;
    lockup_d = 1'b0;
    if (bus_io.load) begin
      cnt_d = '0;
      // A zero state would lock the register forever; substitute SEED instead.
      if (bus_io.load_val == '0) begin
        q_d      = SEED;
        lockup_d = 1'b1;
      end else begin
        q_d = bus_io.load_val;
      end
    end else if (bus_io.en) begin
      q_d = q_step;
      if (q_step == SEED) begin
        wrap_d   = 1'b1;
        period_d = cnt_inc;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge set_n) begin
    if (!set_n) begin
      q_q      <= SEED;
      cnt_q    <= '0;
      period_q <= '0;
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      wrap_q   <= wrap_d;
      lockup_q <= lockup_d;
    end
  end

  assign bus_io.q      = q_q;
  assign bus_io.sout   = GALOIS ? q_q[0] : q_q[WIDTH-1];
  assign bus_io.wrap   = wrap_q;
  assign bus_io.lockup = lockup_q;
  assign bus_io.period = period_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: three instances (4-bit Fibonacci, 4-bit Galois, 8-bit
// Fibonacci) run in lockstep from shared controls. A reference model pushes
// expected outputs into a scoreboard queue each cycle; entries are popped and
// compared one time unit after the clock edge.
module tb_lfsr_gen;

  logic       clk = 1'b0;
  logic       set_n;
  logic       en;
  logic       load;
  logic [7:0] lv;

  always #5 clk = ~clk;

  lfsr_gen_if #(.WIDTH(4)) f_if ();
  lfsr_gen_if #(.WIDTH(4)) g_if ();
  lfsr_gen_if #(.WIDTH(8)) w_if ();

  assign f_if.en = en;
  assign f_if.load = load;
  assign f_if.load_val = lv[3:0];
  assign g_if.en = en;
  assign g_if.load = load;
  assign g_if.load_val = lv[3:0];
  assign w_if.en = en;
  assign w_if.load = load;
  assign w_if.load_val = lv;

  lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .SEED(4'b0001), .GALOIS(1'b0)) u_fib (
    .clk    (clk),
    .set_n  (set_n),
    .bus_io (f_if)
  );

  lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .SEED(4'b0001), .GALOIS(1'b1)) u_gal (
    .clk    (clk),
    .set_n  (set_n),
    .bus_io (g_if)
  );

  lfsr_gen #(.WIDTH(8), .TAPS(8'b10111000), .SEED(8'h01), .GALOIS(1'b0)) u_wide (
    .clk    (clk),
    .set_n  (set_n),
    .bus_io (w_if)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model, one slot per instance.
  int unsigned m_w    [3] = '{4, 4, 8};
  logic [31:0] m_taps [3] = '{32'hC, 32'hC, 32'hB8};
  bit          m_gal  [3] = '{1'b0, 1'b1, 1'b0};
  logic [31:0] m_seed = 32'h1;
  logic [31:0] m_q    [3];
  logic [31:0] m_cnt  [3];
  logic [31:0] m_per  [3];
  logic        m_wrap [3];
  logic        m_lock [3];

  typedef struct {
    int          id;
    logic [31:0] q;
    logic [31:0] period;
    logic        wrap;
    logic        lockup;
    logic        sout;
  } exp_t;

  exp_t sb[$];

  int wrap_cnt [3];
  bit zero_seen;

  function automatic logic [31:0] mask_of(int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
  endfunction

  function automatic logic [31:0] model_step(int d, logic [31:0] s);
    logic [31:0] r;
    logic        fb;
    if (m_gal[d]) begin
      r = s >> 1;
      if (s[0]) r = r ^ m_taps[d];
    end else begin
      fb = 1'b0;
      for (int i = 0; i < int'(m_w[d]); i++) if (m_taps[d][i]) fb = fb ^ s[i];
      r = ((s << 1) | {31'b0, fb}) & mask_of(m_w[d]);
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_q[d] = m_seed;
      m_cnt[d] = 0;
      m_per[d] = 0;
      m_wrap[d] = 1'b0;
      m_lock[d] = 1'b0;
    end
  endtask

  task automatic model_clock(input logic e, input logic l, input logic [7:0] v);
    logic [31:0] lvd, nxt, inc;
    for (int d = 0; d < 3; d++) begin
      lvd = {24'b0, v} & mask_of(m_w[d]);
      m_wrap[d] = 1'b0;
      m_lock[d] = 1'b0;
      if (l) begin
        m_cnt[d] = 0;
        if (lvd == 0) begin
          m_q[d] = m_seed;
          m_lock[d] = 1'b1;
        end else begin
          m_q[d] = lvd;
        end
      end else if (e) begin
        nxt = model_step(d, m_q[d]);
        inc = (m_cnt[d] == mask_of(m_w[d])) ? m_cnt[d] : m_cnt[d] + 1;
        if (nxt == m_seed) begin
          m_wrap[d] = 1'b1;
          m_per[d] = inc;
          m_cnt[d] = 0;
        end else begin
          m_cnt[d] = inc;
        end
        m_q[d] = nxt;
      end
    end
  endtask

  task automatic push_expected();
    exp_t x;
    for (int d = 0; d < 3; d++) begin
      x.id = d;
      x.q = m_q[d];
      x.period = m_per[d];
      x.wrap = m_wrap[d];
      x.lockup = m_lock[d];
      x.sout = m_gal[d] ? m_q[d][0] : m_q[d][m_w[d]-1];
      sb.push_back(x);
    end
  endtask

  task automatic drain();
    exp_t x;
    logic [31:0] aq, ap;
    logic aw, al, as;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      case (x.id)
        0: begin aq = {28'b0, f_if.q}; ap = {28'b0, f_if.period}; aw = f_if.wrap;
                 al = f_if.lockup; as = f_if.sout; end
        1: begin aq = {28'b0, g_if.q}; ap = {28'b0, g_if.period}; aw = g_if.wrap;
                 al = g_if.lockup; as = g_if.sout; end
        default: begin aq = {24'b0, w_if.q}; ap = {24'b0, w_if.period}; aw = w_if.wrap;
                 al = w_if.lockup; as = w_if.sout; end
      endcase
      if (aw === 1'b1) wrap_cnt[x.id]++;
      if (aq == 0) zero_seen = 1'b1;
      check_eq($sformatf("d%0d_q", x.id), aq, x.q);
      check_eq($sformatf("d%0d_period", x.id), ap, x.period);
      check_eq($sformatf("d%0d_wrap", x.id), {31'b0, aw}, {31'b0, x.wrap});
      check_eq($sformatf("d%0d_lockup", x.id), {31'b0, al}, {31'b0, x.lockup});
      check_eq($sformatf("d%0d_sout", x.id), {31'b0, as}, {31'b0, x.sout});
    end
  endtask

  // Called at posedge+1; leaves the bench at the following posedge+1.
  task automatic cycle(input logic e, input logic l, input logic [7:0] v);
    en = e;
    load = l;
    lv = v;
    model_clock(e, l, v);
    push_expected();
    @(posedge clk);
    #1;
    drain();
  endtask

  // Asynchronous reset, checked before any clock edge can intervene.
  task automatic reset_now();
    en = 1'b0;
    load = 1'b0;
    set_n = 1'b0;
    #1;
    model_reset();
    push_expected();
    drain();
    @(posedge clk);
    #1;
    set_n = 1'b1;
  endtask

  task automatic reset_mid();
    #2;
    reset_now();
  endtask

  task automatic clear_stats();
    for (int d = 0; d < 3; d++) wrap_cnt[d] = 0;
    zero_seen = 1'b0;
  endtask

  logic [3:0] fib_tab [7] = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA};
  logic [3:0] gal_tab [4] = '{4'hC, 4'h6, 4'h3, 4'hD};
  int         seen    [16];
  logic [3:0] tv;

  initial begin
    set_n = 1'b1;
    en = 1'b0;
    load = 1'b0;
    lv = 8'h00;
    clear_stats();
    #1;
    reset_now();

    // Known opening sequences for both topologies.
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, 1'b0, 8'h00);
      tv = fib_tab[i];
      check_eq("t1_fib_q", {28'b0, f_if.q}, {28'b0, tv});
      check_eq("t1_fib_sout", {31'b0, f_if.sout}, {31'b0, tv[3]});
      if (i < 4) begin
        tv = gal_tab[i];
        check_eq("t3_gal_q", {28'b0, g_if.q}, {28'b0, tv});
        check_eq("t3_gal_sout", {31'b0, g_if.sout}, {31'b0, tv[0]});
      end
    end

    // Full 4-bit period.
    reset_mid();
    clear_stats();
    for (int s = 0; s < 16; s++) seen[s] = 0;
    for (int i = 0; i < 15; i++) begin
      cycle(1'b1, 1'b0, 8'h00);
      seen[f_if.q]++;
      if (i < 14) check_eq("t2_no_early_wrap", {31'b0, f_if.wrap}, 32'd0);
    end
    check_eq("t2_fib_wrap_last", {31'b0, f_if.wrap}, 32'd1);
    check_eq("t2_fib_q_seed", {28'b0, f_if.q}, 32'h1);
    check_eq("t2_fib_period", {28'b0, f_if.period}, 32'd15);
    check_eq("t2_gal_period", {28'b0, g_if.period}, 32'd15);
    check_eq("t2_fib_wraps", wrap_cnt[0], 32'd1);
    check_eq("t2_gal_wraps", wrap_cnt[1], 32'd1);
    check_eq("t2_zero_state", seen[0], 32'd0);
    for (int s = 1; s < 16; s++) check_eq($sformatf("t2_seen_%0d", s), seen[s], 32'd1);

    // Load beats enable; zero load is replaced by SEED.
    cycle(1'b1, 1'b1, 8'h0B);
    check_eq("t4_load_fib", {28'b0, f_if.q}, 32'hB);
    check_eq("t4_load_gal", {28'b0, g_if.q}, 32'hB);
    check_eq("t4_load_wide", {24'b0, w_if.q}, 32'h0B);
    cycle(1'b0, 1'b1, 8'h00);
    check_eq("t4_zero_q", {28'b0, f_if.q}, 32'h1);
    check_eq("t4_lockup", {31'b0, f_if.lockup}, 32'd1);
    cycle(1'b0, 1'b0, 8'h00);
    check_eq("t4_lockup_clear", {31'b0, f_if.lockup}, 32'd0);

    // Hold, then reset in the middle of a run.
    reset_mid();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'h00);
    check_eq("t5_fib_q5", {28'b0, f_if.q}, 32'h6);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00);
    check_eq("t5_hold_q", {28'b0, f_if.q}, 32'h6);
    check_eq("t5_hold_wrap", {31'b0, f_if.wrap}, 32'd0);
    en = 1'b1;
    reset_mid();
    check_eq("t5_period_reset", {28'b0, f_if.period}, 32'd0);
    for (int i = 0; i < 15; i++) cycle(1'b1, 1'b0, 8'h00);
    check_eq("t5_fib_period", {28'b0, f_if.period}, 32'd15);
    check_eq("t5_gal_period", {28'b0, g_if.period}, 32'd15);

    // 8-bit maximal sequence.
    reset_mid();
    clear_stats();
    for (int i = 0; i < 255; i++) cycle(1'b1, 1'b0, 8'h00);
    check_eq("t6_wide_wraps", wrap_cnt[2], 32'd1);
    check_eq("t6_wide_period", {24'b0, w_if.period}, 32'd255);
    check_eq("t6_wide_q_seed", {24'b0, w_if.q}, 32'h01);
    check_eq("t6_zero_seen", {31'b0, zero_seen}, 32'd0);
    check_eq("t6_fib_wraps", wrap_cnt[0], 32'd17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
Parametrised successor to the team's fixed 4-bit LFSR.
- Width, tap polynomial, seed and topology (Fibonacci or Galois) are set by parameters.
- Adds step enable, parallel load, all-zero lock-up recovery, a serial output, and a hardware period measurement (wrap pulse plus measured period register).
- Serves as the pattern/pseudo-random source for register and counter labs, and as a BIST stimulus generator.

Parameters:
WIDTH, 4, state width in bits; legal range 2..32.
TAPS, 4'b1100, tap mask (WIDTH bits). Default polynomial is x^4+x^3+1. Bit WIDTH-1 must be set.
SEED, 4'b0001, reset and recovery state; must be nonzero (simulation $error at time 0 if zero).
GALOIS, 0, 0 = Fibonacci (external XOR), 1 = Galois (internal XOR).

Ports:
clk  input  1  rising-edge clock
set_n  input  1  asynchronous active-low reset; loads SEED
en  input  1  advance one step this cycle
load  input  1  parallel load; has priority over en
load_val  input  WIDTH  value written on load
q  output  WIDTH  current LFSR state (registered)
sout  output  1  serial bit: q[WIDTH-1] when Fibonacci, q[0] when Galois (combinational from q)
wrap  output  1  one-cycle pulse, registered; see Behaviour
lockup  output  1  one-cycle pulse, registered; load of zero was substituted
period  output  WIDTH  steps between the last two returns to SEED (registered)

Behaviour:
- Reset (set_n=0, asynchronous, any time): q=SEED, wrap=0, lockup=0, period=0, internal step counter cnt=0. Release is synchronous to the next clk edge.
- Priority each rising edge: load > en > hold.
- Load, value nonzero: q<=load_val; cnt<=0; wrap<=0; lockup<=0.
- Load, value zero: q<=SEED; cnt<=0; lockup<=1 for one cycle; wrap<=0.
- Step, Fibonacci: fb = XOR of q[i] for every i with TAPS[i]=1; q<={q[WIDTH-2:0], fb}.
- Step, Galois: q<={1'b0, q[WIDTH-1:1]} ^ ({WIDTH{q[0]}} & TAPS).
- Step counting: cnt<=cnt+1, where cnt is WIDTH bits and saturates at all-ones.
- Step landing on SEED (next q == SEED):
  - wrap<=1 for one cycle;
  - period<=cnt+1, saturating;
  - cnt<=0.
- Hold (en=0, load=0): q, cnt and period unchanged; wrap=0 and lockup=0.
- Zero state is unreachable through stepping. Because of load substitution and the nonzero SEED, q is never 0.
- Latency: q, wrap and period update on the same edge that takes the step. period is visible one cycle after the wrap edge's inputs were applied, i.e. coincident with wrap=1.
- A non-maximal TAPS gives a short cycle. period reports the true cycle length as long as the cycle passes through SEED. If it never does, wrap never fires and period keeps its old value.
- en held high for 2^WIDTH-1 steps with a primitive TAPS gives wrap exactly once per 2^WIDTH-1 steps.

Test Plan:
1. Reset defaults, Fibonacci: pulse set_n low mid-cycle -> q=0001 immediately (asynchronous). Then en=1 for 7 cycles -> q = 0010, 0100, 1001, 0011, 0110, 1101, 1010; sout follows q[3].
2. Full period, Fibonacci: en=1 for 15 cycles from SEED -> wrap=1 only on the 15th step with q=0001; period=15; all 15 nonzero states seen exactly once.
3. Galois mode (GALOIS=1, defaults otherwise): from 0001, steps give 1100, 0110, 0011, 1101. After 15 steps wrap=1 and period=15; sout follows q[0].
4. Load and lock-up: load=1 with load_val=1011 and en=1 -> q=1011, no step taken. load=1 with load_val=0000 -> q=0001, lockup=1 for exactly one cycle.
5. Hold and reset mid-run: step 5 times, drop en for 3 cycles -> q stable, wrap=0. Assert set_n=0 mid-step -> q=0001, period=0, and the next full run still measures period=15.
6. Wide configuration: WIDTH=8, TAPS=8'b10111000, SEED=8'h01, en=1 for 255 cycles -> single wrap pulse, period=255, q never 0.
